// File: rtl/fir_arbiter.sv
// fir_arbiter: two-channel round-robin front end for a single shared FIR engine.
// Takes one sample at a time, launches the engine with a one-cycle start pulse,
// waits ENG_LAT cycles and returns the result tagged with its owning channel.
module fir_arbiter #(
   parameter int DW      = 16,
   parameter int ENG_LAT = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          s0_valid,
   input  logic [DW-1:0] s0_data,
   output logic          s0_ready,
   input  logic          s1_valid,
   input  logic [DW-1:0] s1_data,
   output logic          s1_ready,
   input  logic [1:0]    ch_en,
   output logic          eng_start,
   output logic [DW-1:0] eng_x,
   input  logic [DW-1:0] eng_y,
   output logic          m_valid,
   output logic          m_ch,
   output logic [DW-1:0] m_data,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

   state_t        state;
   logic [7:0]    cnt;
   logic          last_grant;
   logic          pend_ch;
   logic          c0, c1, gnt, hs;
   logic [DW-1:0] sel_data;

   // Candidates exist only in IDLE; on a tie the channel not served last wins.
   always_comb begin
      c0       = (state == IDLE) & s0_valid & ch_en[0];
      c1       = (state == IDLE) & s1_valid & ch_en[1];
      gnt      = (c0 & c1) ? ~last_grant : c1;
      s0_ready = c0 & ~gnt;
      s1_ready = c1 & gnt;
      hs       = c0 | c1;
      sel_data = gnt ? s1_data : s0_data;
      busy     = (state != IDLE);
   end

   // Sequencer: accept, pulse the engine, count down its latency, emit the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= 1'b1;
         pend_ch    <= 1'b0;
         eng_start  <= 1'b0;
         eng_x      <= '0;
         m_valid    <= 1'b0;
         m_ch       <= 1'b0;
         m_data     <= '0;
      end else begin
         eng_start <= 1'b0;
         m_valid   <= 1'b0;
         case (state)
            IDLE: begin
               if (hs) begin
                  eng_x      <= sel_data;
                  pend_ch    <= gnt;
                  last_grant <= gnt;
                  eng_start  <= 1'b1;
                  state      <= START;
               end
            end
            START: begin
               cnt   <= 8'(ENG_LAT - 1);
               state <= WAIT;
            end
            WAIT: begin
               if (cnt == 8'd0) begin
                  // eng_y is valid in this cycle; pass it through untouched
                  m_data  <= eng_y;
                  m_ch    <= pend_ch;
                  m_valid <= 1'b1;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_arbiter.sv
// tb_fir_arbiter: directed stimulus, scoreboard of expected results popped by a
// monitor on every m_valid; engine is modelled as an ENG_LAT-cycle echo.
module tb_fir_arbiter;

   localparam int DW      = 16;
   localparam int ENG_LAT = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          s0_valid, s1_valid, s0_ready, s1_ready;
   logic [DW-1:0] s0_data, s1_data;
   logic [1:0]    ch_en;
   logic          eng_start, m_valid, m_ch, busy;
   logic [DW-1:0] eng_x, eng_y, m_data;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int mv_cnt = 0;

   // scoreboard and grant log
   bit            exp_ch[$];
   logic [DW-1:0] exp_data[$];
   int            exp_cyc[$];
   bit            g_ch[$];
   int            g_cyc[$];
   int            last_hs_cyc = -100;
   logic [DW-1:0] last_hs_data = '0;

   logic [DW-1:0] dl [ENG_LAT];

   fir_arbiter #(.DW(DW), .ENG_LAT(ENG_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
      .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
      .ch_en(ch_en), .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
      .m_valid(m_valid), .m_ch(m_ch), .m_data(m_data), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // engine model: echoes x exactly ENG_LAT cycles after the start cycle, junk otherwise
   always @(posedge clk) begin
      dl[0] <= eng_start ? eng_x : 16'hDEAD;
      for (int i = 1; i < ENG_LAT; i++) dl[i] <= dl[i-1];
   end
   assign eng_y = dl[ENG_LAT-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: log handshakes into the scoreboard, check engine pulse and results
   always @(negedge clk) begin
      if (rst_n) begin
         if (s0_ready && s1_ready) chk("both_ready", 1, 0);
         if (s0_valid && !ch_en[0]) chk("s0_ready_disabled", 32'(s0_ready), 0);
         if (s0_valid && s0_ready) begin
            exp_ch.push_back(1'b0); exp_data.push_back(s0_data);
            exp_cyc.push_back(cyc + ENG_LAT + 2);
            g_ch.push_back(1'b0); g_cyc.push_back(cyc);
            last_hs_cyc = cyc; last_hs_data = s0_data;
         end
         if (s1_valid && s1_ready) begin
            exp_ch.push_back(1'b1); exp_data.push_back(s1_data);
            exp_cyc.push_back(cyc + ENG_LAT + 2);
            g_ch.push_back(1'b1); g_cyc.push_back(cyc);
            last_hs_cyc = cyc; last_hs_data = s1_data;
         end
         if (eng_start) begin
            chk("eng_start_cycle", 32'(cyc), 32'(last_hs_cyc + 1));
            chk("eng_x", 32'(eng_x), 32'(last_hs_data));
         end
         if (m_valid) begin
            mv_cnt++;
            if (exp_ch.size() == 0) chk("m_valid_unexpected", 1, 0);
            else begin
               chk("m_ch", 32'(m_ch), 32'(exp_ch.pop_front()));
               chk("m_data", 32'(m_data), 32'(exp_data.pop_front()));
               chk("m_valid_cycle", 32'(cyc), 32'(exp_cyc.pop_front()));
            end
         end
      end
   end

   task automatic drive_idle();
      s0_valid = 0; s1_valid = 0; s0_data = '0; s1_data = '0;
   endtask

   // offer one sample on one channel and drop it after its handshake
   task automatic send(input bit ch, input logic [DW-1:0] d);
      int n0 = g_ch.size();
      bit done = 0;
      if (ch) begin s1_valid = 1; s1_data = d; end
      else    begin s0_valid = 1; s0_data = d; end
      for (int k = 0; k < 40 && !done; k++) begin
         @(posedge clk);
         if (g_ch.size() > n0) done = 1;
      end
      if (!done) chk("send_timeout", 0, 1);
      #1;
      if (ch) s1_valid = 0; else s0_valid = 0;
   endtask

   task automatic wait_grants(input int n);
      bit done = 0;
      for (int k = 0; k < 100 && !done; k++) begin
         @(posedge clk);
         if (g_ch.size() >= n) done = 1;
      end
      if (!done) chk("grant_timeout", 0, 1);
      #1;
   endtask

   task automatic drain();
      bit done = 0;
      for (int k = 0; k < 60 && !done; k++) begin
         @(posedge clk);
         if (exp_ch.size() == 0) done = 1;
      end
      if (!done) chk("drain_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 0; drive_idle();
      exp_ch.delete(); exp_data.delete(); exp_cyc.delete();
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int t0, base;
      ch_en = 2'b11;
      do_reset();
      // reset state
      chk("rst_eng_start", 32'(eng_start), 0);
      chk("rst_eng_x", 32'(eng_x), 0);
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_m_ch", 32'(m_ch), 0);
      chk("rst_m_data", 32'(m_data), 0);
      chk("rst_busy", 32'(busy), 0);
      rst_n = 1;
      @(posedge clk); #1;

      // single sample and a negative sample, echoed unmodified
      send(1'b0, 16'h1000);
      drain();
      send(1'b0, 16'h8000);
      drain();

      // contention straight out of reset: 0,1,0,1 every ENG_LAT+2 cycles
      do_reset();
      g_ch.delete(); g_cyc.delete();
      t0 = cyc;
      rst_n = 1;
      s0_valid = 1; s0_data = 16'hA000;
      s1_valid = 1; s1_data = 16'h0B0B;
      wait_grants(4);
      drive_idle();
      chk("first_hs_cycle", 32'(g_cyc[0]), 32'(t0));
      chk("cont_g0", 32'(g_ch[0]), 0);
      chk("cont_g1", 32'(g_ch[1]), 1);
      chk("cont_g2", 32'(g_ch[2]), 0);
      chk("cont_g3", 32'(g_ch[3]), 1);
      chk("cont_spacing", 32'(g_cyc[3] - g_cyc[0]), 32'(3 * (ENG_LAT + 2)));
      drain();

      // channel 0 disabled: only channel 1 is served
      g_ch.delete(); g_cyc.delete();
      ch_en = 2'b10;
      s0_valid = 1; s0_data = 16'h1111;
      s1_valid = 1; s1_data = 16'h2222;
      wait_grants(3);
      drive_idle();
      chk("en_g0", 32'(g_ch[0]), 1);
      chk("en_g1", 32'(g_ch[1]), 1);
      chk("en_g2", 32'(g_ch[2]), 1);
      drain();
      ch_en = 2'b11;

      // channel 1 arrives during channel 0 WAIT; accepted in channel 0's m_valid cycle
      g_ch.delete(); g_cyc.delete();
      send(1'b0, 16'h3333);
      repeat (3) @(posedge clk);
      #1;
      s1_valid = 1; s1_data = 16'h4444;
      wait_grants(2);
      drive_idle();
      chk("bp_ch", 32'(g_ch[1]), 1);
      chk("bp_accept_cycle", 32'(g_cyc[1] - g_cyc[0]), 32'(ENG_LAT + 2));
      drain();

      // reset in WAIT cycle 4 discards the in-flight sample
      g_ch.delete(); g_cyc.delete();
      send(1'b0, 16'h5555);
      chk("mid_busy_before", 32'(busy), 1);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 0;
      exp_ch.delete(); exp_data.delete(); exp_cyc.delete();
      #1;
      chk("mid_eng_x", 32'(eng_x), 0);
      chk("mid_busy", 32'(busy), 0);
      chk("mid_m_valid", 32'(m_valid), 0);
      chk("mid_eng_start", 32'(eng_start), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      base = mv_cnt;
      repeat (ENG_LAT + 6) @(posedge clk);
      #1;
      chk("mid_no_m_valid", 32'(mv_cnt - base), 0);
      send(1'b1, 16'h0123);
      drain();

      chk("sb_empty", 32'(exp_ch.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
